// File: rtl/upscaler_stream_pkg.sv
// Shared types and helpers for the upscaler output stream path.
// Holds the mux FSM encoding, the mode encodings and the channel-index width function.
package upscaler_stream_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first requester at or after ptr, wrapping to 0.
// The wrap is an explicit compare, so non-power-of-2 channel counts behave correctly.
module rr_arbiter
  import upscaler_stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
      idx = (idx == SEL_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 pixel-stream mux, round-robin or fixed select, grant held for a whole packet.
// A single output register slice gives one beat of latency at full throughput.
module stream_mux_rr
  import upscaler_stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_fixed,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready,
  output logic                     busy
);

  state_e             state;
  logic [SEL_W-1:0]   lock_ch;
  logic [SEL_W-1:0]   rr_ptr;
  logic               rr_valid;
  logic [SEL_W-1:0]   rr_idx;
  logic               gnt_valid;
  logic [SEL_W-1:0]   gnt_idx;
  logic               load_ok;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  logic [SEL_W-1:0]   next_ptr;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Config is only honoured in IDLE; a locked packet ignores cfg_* and other requesters.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (state == ST_LOCKED) begin
      gnt_valid = in_valid[lock_ch];
      gnt_idx   = lock_ch;
    end else if (cfg_fixed == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else if (int'(cfg_sel) < NUM_CH) begin
      gnt_valid = in_valid[cfg_sel];
      gnt_idx   = cfg_sel;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_idx == SEL_W'(c)) begin
        sel_data = in_data[c*DATA_W +: DATA_W];
        sel_last = in_last[c];
      end
    end
  end

  assign load_ok  = !out_valid || out_ready;
  assign accept   = !rst && load_ok && gnt_valid;
  assign next_ptr = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  assign busy     = (state == ST_LOCKED);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lock_ch   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= gnt_idx;
      if (sel_last) begin
        state  <= ST_IDLE;
        rr_ptr <= next_ptr;
      end else begin
        state   <= ST_LOCKED;
        lock_ch <= gnt_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and randomized checks of stream_mux_rr against a packet-level reference model.
// A second, 3-channel instance covers the out-of-range fixed-select case.
module tb_stream_mux_rr;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_fixed;
  logic [SEL_W-1:0]         cfg_sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;
  logic                     busy;

  logic                     c3_fixed;
  logic [1:0]               c3_sel;
  logic [2:0]               c3_valid;
  logic [3*DATA_W-1:0]      c3_data;
  logic [2:0]               c3_last;
  logic [2:0]               c3_ready;
  logic                     c3_ov;
  logic [DATA_W-1:0]        c3_od;
  logic                     c3_ol;
  logic [1:0]               c3_och;
  logic                     c3_busy;

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .cfg_fixed(cfg_fixed), .cfg_sel(cfg_sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready), .busy(busy)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(DATA_W)) dut3 (
    .clk(clk), .rst(rst), .cfg_fixed(c3_fixed), .cfg_sel(c3_sel),
    .in_valid(c3_valid), .in_data(c3_data), .in_last(c3_last), .in_ready(c3_ready),
    .out_valid(c3_ov), .out_data(c3_od), .out_last(c3_ol), .out_ch(c3_och),
    .out_ready(1'b1), .busy(c3_busy)
  );

  int checks   = 0;
  int failures = 0;
  int sent     = 0;
  int recv     = 0;

  // reference model: packet lock, rr pointer and the output slot
  bit                       m_locked  = 0;
  int                       m_lock_ch = 0;
  int                       m_ptr     = 0;
  bit                       m_ov      = 0;
  logic [DATA_W-1:0]        m_od      = '0;
  logic                     m_ol      = 1'b0;
  int                       m_och     = 0;
  logic [NUM_CH-1:0]        last_acc  = '0;
  logic [SEL_W+DATA_W:0]    sb[$];
  int                       rem[NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input bit v, input bit l, input logic [DATA_W-1:0] d);
    in_valid[c]                = v;
    in_last[c]                 = l;
    in_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle_all();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 0, 0, 8'h00);
  endtask

  // one clock: check in_ready before the edge, advance model, check outputs at negedge
  task automatic cycle();
    int g;
    bit load_ok;
    logic [NUM_CH-1:0] exp_rdy;
    logic [SEL_W+DATA_W:0] item;
    #1;
    g = -1;
    if (m_locked) begin
      if (in_valid[m_lock_ch]) g = m_lock_ch;
    end else if (cfg_fixed) begin
      if (int'(cfg_sel) < NUM_CH && in_valid[cfg_sel]) g = int'(cfg_sel);
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (g < 0 && in_valid[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
    end
    load_ok = !m_ov || out_ready;
    exp_rdy = '0;
    if (!rst && load_ok && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid === 1'b1 && out_ready) begin
      recv++;
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        chk("sb_beat", 32'({out_ch, out_last, out_data}), 32'(item));
      end
    end
    last_acc = exp_rdy;
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_lock_ch = 0; m_ptr = 0;
      m_ov = 0; m_od = '0; m_ol = 1'b0; m_och = 0;
      sb.delete();
    end else if (exp_rdy != '0) begin
      m_ov  = 1;
      m_od  = in_data[g*DATA_W +: DATA_W];
      m_ol  = in_last[g];
      m_och = g;
      sb.push_back({SEL_W'(g), m_ol, m_od});
      sent++;
      if (m_ol) begin
        m_locked = 0;
        m_ptr    = (g + 1) % NUM_CH;
      end else begin
        m_locked  = 1;
        m_lock_ch = g;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_last", 32'(out_last), 32'(m_ol));
      chk("out_ch", 32'(out_ch), 32'(m_och));
    end
    chk("busy", 32'(busy), 32'(m_locked));
  endtask

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; cfg_fixed = 1'b0; cfg_sel = '0; out_ready = 1'b1;
    in_valid = '0; in_data = '0; in_last = '0;
    c3_fixed = 1'b0; c3_sel = '0; c3_valid = '0; c3_data = '0; c3_last = '0;
    @(negedge clk);

    // reset with every channel requesting
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1, 1, 8'hA0 + 8'(c));
    cycle();
    cycle();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // round-robin single-beat packets
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_seq_ch", 32'(out_ch), 32'(rr_exp[i]));
      chk("rr_seq_data", 32'(out_data), 32'(8'hA0 + 8'(rr_exp[i])));
    end

    // packet lock: ptr moves to ch2, yet ch1 keeps the grant until its last beat
    idle_all();
    set_ch(1, 1, 1, 8'h10);
    cycle();
    set_ch(1, 1, 0, 8'h11);
    cycle();
    chk("lock_b1", 32'({busy, out_data}), 32'({1'b1, 8'h11}));
    set_ch(2, 1, 1, 8'h22);
    set_ch(1, 1, 0, 8'h12);
    cycle();
    chk("lock_b2", 32'({busy, out_ch, out_data}), 32'({1'b1, 2'd1, 8'h12}));
    set_ch(1, 1, 1, 8'h13);
    cycle();
    chk("lock_b3", 32'({busy, out_ch, out_data}), 32'({1'b0, 2'd1, 8'h13}));
    set_ch(1, 0, 0, 8'h00);
    cycle();
    chk("lock_next", 32'({out_ch, out_data}), 32'({2'd2, 8'h22}));
    idle_all();
    cycle();

    // downstream backpressure mid-packet
    set_ch(0, 1, 0, 8'h30);
    cycle();
    set_ch(0, 1, 0, 8'h31);
    cycle();
    set_ch(0, 1, 0, 8'h32);
    set_ch(3, 1, 1, 8'h70);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold", 32'(out_data), 32'h31);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    set_ch(0, 1, 1, 8'h33);
    cycle();
    set_ch(0, 0, 0, 8'h00);
    cycle();
    chk("bp_after", 32'(out_ch), 32'd3);
    idle_all();
    cycle();
    cycle();
    chk("bp_count", 32'(recv), 32'(sent));

    // fixed select, cfg change mid-packet deferred to packet end
    cfg_fixed = 1'b1; cfg_sel = 2'd3;
    set_ch(0, 1, 1, 8'h50);
    set_ch(3, 1, 0, 8'h41);
    cycle();
    chk("fix_b1", 32'(out_ch), 32'd3);
    cfg_sel = 2'd0;
    set_ch(3, 1, 0, 8'h42);
    cycle();
    chk("fix_b2", 32'(out_ch), 32'd3);
    set_ch(3, 1, 1, 8'h43);
    cycle();
    chk("fix_b3", 32'({busy, out_ch}), 32'({1'b0, 2'd3}));
    set_ch(3, 0, 0, 8'h00);
    cycle();
    chk("fix_switch", 32'({out_ch, out_data}), 32'({2'd0, 8'h50}));
    idle_all();
    cfg_fixed = 1'b0;
    cycle();

    // fixed select out of range on a 3-channel mux
    c3_fixed = 1'b1; c3_sel = 2'd3; c3_valid = 3'b111; c3_last = 3'b111;
    c3_data = {8'hC2, 8'hC1, 8'hC0};
    cycle();
    chk("c3_noready", 32'(c3_ready), 32'd0);
    chk("c3_nogrant", 32'(c3_ov), 32'd0);
    c3_sel = 2'd2;
    #1;
    chk("c3_ready2", 32'(c3_ready), 32'b100);
    cycle();
    chk("c3_out", 32'({c3_ov, c3_och, c3_od}), 32'({1'b1, 2'd2, 8'hC2}));
    c3_valid = '0;

    // reset during beat 2 of a 4-beat packet
    set_ch(2, 1, 0, 8'h61);
    cycle();
    set_ch(2, 1, 0, 8'h62);
    rst = 1'b1;
    cycle();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1, 1, 8'hA0 + 8'(c));
    cycle();
    chk("mrst_restart", 32'(out_ch), 32'd0);
    idle_all();
    cycle();

    // randomized traffic
    for (int c = 0; c < NUM_CH; c++) rem[c] = 0;
    last_acc = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg_fixed = 1'($urandom_range(0, 1));
        cfg_sel   = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (last_acc[c] && rem[c] > 0) rem[c]--;
        if (last_acc[c] || !in_valid[c]) begin
          if (rem[c] == 0) rem[c] = $urandom_range(1, 4);
          set_ch(c, ($urandom_range(0, 4) != 0), (rem[c] == 1), 8'($urandom));
        end
      end
      cycle();
    end
    idle_all();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit pixel-stream multiplexer with valid/ready handshake and a registered output stage.
- Selects one of NUM_CH input streams in either round-robin or fixed-select mode.
- Holds its grant for a whole packet (a line of pixels, terminated by last).
- Sits between the parallel per-tile upscaler lanes and the single output line writer. It is the sequential, multi-channel successor of the gate-level 2:1 select.

Parameters:
- NUM_CH, 4, number of input channels (>= 2).
- DATA_W, 8, pixel/beat width in bits.
- SEL_W, max(1, clog2(NUM_CH)), channel index width. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- cfg_fixed  in  1  0 = round-robin, 1 = fixed select.
- cfg_sel  in  SEL_W  channel used when cfg_fixed = 1.
- in_valid  in  NUM_CH  per-channel beat valid.
- in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- in_last  in  NUM_CH  per-channel end-of-packet flag.
- in_ready  out  NUM_CH  per-channel accept.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output beat.
- out_last  out  1  end-of-packet for the output beat.
- out_ch  out  SEL_W  source channel of the output beat.
- out_ready  in  1  downstream accept.
- busy  out  1  high while a packet is locked (state LOCKED).

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge):
  - out_valid, out_data, out_last, out_ch, rr_ptr and lock_ch all go to 0; state goes to IDLE.
  - in_ready is forced to all-0 combinationally while rst is high.
- Handshake:
  - Input transfer on channel c occurs when in_valid[c] && in_ready[c].
  - Output transfer occurs when out_valid && out_ready.
  - in_ready may depend combinationally on in_valid; in_valid must never depend on in_ready.
- Output register:
  - load = (!out_valid || out_ready) && (a grant exists).
  - At most one in_ready bit is high, and only when load is possible.
  - An accepted beat appears on out_* the next cycle (latency 1 cycle).
  - Throughput is 1 beat/clk while out_ready = 1.
  - out_data, out_last and out_ch stay stable while out_valid && !out_ready.
  - out_valid clears when out_ready = 1 and no new beat is accepted.
- State machine:
  - States are IDLE and LOCKED.
  - IDLE, round-robin: grant goes to the first c with in_valid[c], searching rr_ptr, rr_ptr+1, ... and wrapping NUM_CH-1 -> 0.
  - IDLE, fixed: grant goes to cfg_sel if in_valid[cfg_sel]. No grant if cfg_sel >= NUM_CH.
  - IDLE, accepted beat with last = 0: go to LOCKED, lock_ch = granted channel.
  - IDLE, accepted beat with last = 1 (single-beat packet): stay in IDLE, rr_ptr = granted + 1 (mod NUM_CH).
  - LOCKED: grant goes to lock_ch only, regardless of cfg_* or other valids.
  - LOCKED, accepted beat with last = 1: go to IDLE, rr_ptr = lock_ch + 1 (mod NUM_CH).
  - rr_ptr updates in fixed mode too.
- Boundary conditions:
  - cfg_fixed/cfg_sel are sampled only in IDLE. Changes mid-packet take effect after the last beat.
  - Locked channel drops in_valid mid-packet: the lock holds, no beats move, and all other channels stall. There is no timeout.
  - Downstream stall: in_ready = 0 on every channel, and the arbiter state is frozen.
  - Reset mid-packet: the output beat is discarded, state returns to IDLE, and the partial packet is not completed.
  - Non-power-of-2 NUM_CH: the wrap uses an explicit compare with NUM_CH-1, never an implicit overflow.

Decomposition:
- Package upscaler_stream_pkg holds:
  - the state enum (ST_IDLE, ST_LOCKED);
  - the mode encodings (MODE_RR = 0, MODE_FIXED = 1);
  - a constant function sel_width(n) returning max(1, clog2(n)).
- Sub-module rr_arbiter: purely combinational, parametrised NUM_CH.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
  - Instantiated once; the fixed-mode override is applied in the parent.

Test Plan:
- Reset: assert rst with all in_valid = 4'b1111 -> in_ready = 0, out_valid = 0. First grant after release goes to ch0 (rr_ptr = 0).
- Round-robin single-beat: cfg_fixed = 0, all channels valid with last = 1 every beat, out_ready = 1 -> out_ch sequence 0, 1, 2, 3, 0, with one beat per clk and out_data matching each channel's pattern (0xA0+c).
- Packet lock: ch1 sends a 3-beat packet (0x11, 0x12, 0x13 with last on 0x13) while ch2 is valid -> three ch1 beats are contiguous with busy = 1, then ch2 is granted and busy drops after 0x13 is accepted.
- Backpressure: out_ready = 0 for 5 clk mid-packet -> out_data holds and in_ready = 0. No beat is lost or duplicated after release; the scoreboard count equals the sent count.
- Fixed mode and mid-packet cfg change: cfg_fixed = 1, cfg_sel = 3, with ch0 and ch3 valid -> only ch3 is granted. Switching cfg_sel to 0 mid-packet has no effect until ch3's last beat, then ch0 is granted. cfg_sel = 3 with NUM_CH = 3 -> no grant.
- Reset mid-packet: assert rst during beat 2 of a 4-beat packet -> next cycle out_valid = 0, busy = 0, and arbitration restarts from ch0.
